// File: rtl/pe_pkg.sv
// Shared widths and mode encodings for the processing-element family.
package pe_pkg;
  localparam int PE_DATA_W   = 8;
  localparam int PE_ACC_W    = 16;
  localparam int PE_UNSIGNED = 0;
  localparam int PE_SIGNED   = 1;
  localparam int PE_WRAP     = 0;
  localparam int PE_SATURATE = 1;
endpackage

// File: rtl/pe_sat_add.sv
// Extends a product to accumulator width and adds it to a partial sum, wrapping or clamping.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W  = PE_ACC_W,
  parameter int PROD_W = 2 * PE_DATA_W,
  parameter int SIGNED = PE_UNSIGNED,
  parameter int SAT    = PE_WRAP
) (
  input  logic [PROD_W-1:0] prod_i,
  input  logic [ACC_W-1:0]  psum_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   raw;
  logic             ovf_u;
  logic             ovf_s;

  always_comb begin
    if (SIGNED == PE_SIGNED) prod_ext = ACC_W'($signed(prod_i));
    else                     prod_ext = ACC_W'(prod_i);
    raw   = {1'b0, psum_i} + {1'b0, prod_ext};
    ovf_u = raw[ACC_W];
    // signed overflow: operands agree in sign but the result does not
    ovf_s = (psum_i[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != psum_i[ACC_W-1]);
    sum_o = raw[ACC_W-1:0];
    if (SAT == PE_SATURATE) begin
      if (SIGNED == PE_SIGNED) begin
        if (ovf_s) sum_o = psum_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else if (ovf_u) begin
        sum_o = '1;
      end
    end
  end

endmodule

// File: rtl/pe_db.sv
// Systolic processing element with double-buffered weight and a 2-stage multiply-accumulate.
module pe_db
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W,
  parameter int SIGNED = PE_UNSIGNED,
  parameter int SAT    = PE_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [DATA_W-1:0] datain,
  input  logic [ACC_W-1:0]  sumin,
  input  logic [DATA_W-1:0] win,
  input  logic              wwrite,
  input  logic              wswap,
  output logic [DATA_W-1:0] dataout,
  output logic              activeout,
  output logic [DATA_W-1:0] wout,
  output logic              wwriteout,
  output logic              wswapout,
  output logic [ACC_W-1:0]  maccout,
  output logic              macvalid
);

  localparam int PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("pe_db: ACC_W must be at least 2*DATA_W");
  end

  logic [DATA_W-1:0] shadow_q, work_q, dataout_q, wout_q;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]  psum_q, macc_q, macc_d;
  logic              v1_q, activeout_q, wwriteout_q, wswapout_q, macvalid_q;

  always_comb begin
    if (SIGNED == PE_SIGNED)
      prod_d = $signed(PROD_W'($signed(datain))) * $signed(PROD_W'($signed(work_q)));
    else
      prod_d = PROD_W'(datain) * PROD_W'(work_q);
  end

  pe_sat_add #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W),
    .SIGNED(SIGNED),
    .SAT   (SAT)
  ) u_sat_add (
    .prod_i(prod_q),
    .psum_i(psum_q),
    .sum_o (macc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      work_q      <= '0;
      wout_q      <= '0;
      prod_q      <= '0;
      psum_q      <= '0;
      v1_q        <= 1'b0;
      dataout_q   <= '0;
      activeout_q <= 1'b0;
      wwriteout_q <= 1'b0;
      wswapout_q  <= 1'b0;
      macc_q      <= '0;
      macvalid_q  <= 1'b0;
    end else begin
      dataout_q   <= datain;
      activeout_q <= active;
      wwriteout_q <= wwrite;
      wswapout_q  <= wswap;
      if (wwrite) begin
        shadow_q <= win;
        wout_q   <= win;
      end
      // swap takes the pre-edge shadow, so a same-cycle write lands only in shadow
      if (wswap) work_q <= shadow_q;
      v1_q <= active;
      if (active) begin
        prod_q <= prod_d;
        psum_q <= sumin;
      end
      macvalid_q <= v1_q;
      if (v1_q) macc_q <= macc_d;
    end
  end

  assign dataout   = dataout_q;
  assign activeout = activeout_q;
  assign wout      = wout_q;
  assign wwriteout = wwriteout_q;
  assign wswapout  = wswapout_q;
  assign maccout   = macc_q;
  assign macvalid  = macvalid_q;

endmodule

// File: doc/pe_db.md
PE_DB -- requirements
Module: pe_db

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of data and weight.
REQ-002 SHALL have parameter ACC_W, default 16, meaning the accumulator width; ACC_W >= 2*DATA_W, elaboration error otherwise.
REQ-003 SHALL have parameter SIGNED, default 0, meaning 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 SHALL have parameter SAT, default 0, meaning 0 = wrap-around sum, 1 = saturating sum.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port active  in  1  datain/sumin valid this cycle.
REQ-008 SHALL have port datain  in  DATA_W  activation from left neighbour.
REQ-009 SHALL have port sumin  in  ACC_W  partial sum from upper neighbour.
REQ-010 SHALL have port win  in  DATA_W  weight from upper neighbour.
REQ-011 SHALL have port wwrite  in  1  load win into shadow weight.
REQ-012 SHALL have port wswap  in  1  copy shadow weight into working weight.
REQ-013 SHALL have port dataout  out  DATA_W  datain delayed 1 cycle.
REQ-014 SHALL have port activeout  out  1  active delayed 1 cycle.
REQ-015 SHALL have port wout  out  DATA_W  last weight written; forwarded down the column.
REQ-016 SHALL have port wwriteout  out  1  wwrite delayed 1 cycle.
REQ-017 SHALL have port wswapout  out  1  wswap delayed 1 cycle.
REQ-018 SHALL have port maccout  out  ACC_W  sumin + datain*working weight.
REQ-019 SHALL have port macvalid  out  1  maccout updated this cycle.

Function
REQ-020 SHALL hold two weight registers, shadow_w and work_w, each DATA_W bits.
REQ-021 SHALL, when wwrite=1, load shadow_w and wout with win at the edge; when wwrite=0, both hold their value.
REQ-022 SHALL, when wswap=1, load work_w with the pre-edge value of shadow_w.
- Simultaneous wwrite and wswap: work_w gets the old shadow_w; shadow_w gets win.
REQ-023 SHALL register dataout<=datain, activeout<=active, wwriteout<=wwrite and wswapout<=wswap every cycle, regardless of active.
REQ-024 SHALL run a 2-stage MAC pipeline.
- Stage 1, when active=1: prod<=datain*work_w, using the pre-edge work_w; psum<=sumin; v1<=1.
- Stage 1, when active=0: prod and psum hold; v1<=0.
REQ-025 SHALL run stage 2 when v1=1: maccout<=psum+prod; macvalid<=1. When v1=0: maccout holds; macvalid<=0.
- Latency from active sample to macvalid is exactly 2 cycles; one result per cycle at full throughput.
REQ-026 SHALL form prod at 2*DATA_W bits, then sign-extend (SIGNED=1) or zero-extend (SIGNED=0) it to ACC_W.
REQ-027 SHALL, when SAT=0, produce the sum modulo 2^ACC_W.
REQ-028 SHALL, when SAT=1, clamp on overflow.
- Unsigned: clamp to 2^ACC_W-1.
- Signed: clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1), per overflow direction.
REQ-029 SHALL have no combinational path from any input to any output.

Reset
REQ-030 SHALL, when rst=1 at an edge, clear shadow_w, work_w, prod, psum, v1 and all outputs to 0; rst takes priority over every other input.
REQ-031 SHALL discard in-flight pipeline data on reset mid-operation; macvalid is 0 on the cycle after reset and stays 0 until 2 cycles after the first post-reset active=1.

Structure
REQ-032 SHALL take default widths (DATA_W=8, ACC_W=16) and the mode encodings for SIGNED and SAT from shared package pe_pkg.
REQ-033 SHALL place extension, add, wrap and saturate logic in one combinational sub-module, pe_sat_add (parameters ACC_W, SIGNED, SAT), reusable by the later array-level accumulator.

Verification (DATA_W=8, ACC_W=16)
REQ-034 SHALL cover weight isolation: wwrite=1 with win=0x05, no swap; then active=1, datain=0x03, sumin=0x0000 -> maccout=0x0000 with macvalid=1 two cycles later; wout=0x05.
REQ-035 SHALL cover swap: wswap=1 after REQ-034; then active=1, datain=0x03, sumin=0x0010 -> maccout=0x001F two cycles later; wswapout pulses 1 cycle after wswap.
REQ-036 SHALL cover simultaneous write and swap: shadow_w=0x05; one cycle with wwrite=1, wswap=1, win=0x07 -> work_w=0x05, shadow_w=0x07; a following MAC with datain=0x01, sumin=0 gives 0x0005.
REQ-037 SHALL cover signed mode: SIGNED=1, work_w=0xFE, datain=0x03, sumin=0x0010 -> maccout=0x000A.
REQ-038 SHALL cover overflow: SIGNED=0, work_w=0xFF, datain=0xFF, sumin=0xFFFF -> SAT=0 gives 0xFE00; SAT=1 gives 0xFFFF.
REQ-039 SHALL cover reset mid-stream: back-to-back active for 4 cycles, rst=1 in cycle 3 -> all outputs 0 the next cycle, no macvalid until 2 cycles after active resumes, and work_w=0.
